// File: rtl/ublf_pkg.sv
// Shared helpers for the Ladner-Fischer subtractor pipeline.
// Prefix operator, level count and combine-source index.
package ublf_pkg;

   typedef struct packed {
      logic bout;
      logic zero;
      logic ovf;
   } flags_t;

   function automatic logic [1:0] carry_op(
      input logic gi1,
      input logic pi1,
      input logic gi2,
      input logic pi2
   );
      return {gi1 | (pi1 & gi2), pi1 & pi2};
   endfunction

   function automatic int levels(input int w);
      int n;
      n = 0;
      while ((1 << n) < w) n = n + 1;
      return n;
   endfunction

   function automatic bit is_pow2(input int w);
      return (w > 0) && ((w & (w - 1)) == 0);
   endfunction

   // Highest bit of the group just below the block bit i belongs to at level k
   function automatic int lf_partner(input int i, input int k);
      return ((i >> (k - 1)) << (k - 1)) - 1;
   endfunction

endpackage

// File: rtl/ublf_prefix_levels.sv
// Combinational Ladner-Fischer prefix levels FIRST..LAST.
// Each bit with bit k-1 of its index set merges with the group below its block.
module ublf_prefix_levels
   import ublf_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FIRST = 1,
   parameter int LAST  = 2
) (
   input  logic [WIDTH-1:0] g_in,
   input  logic [WIDTH-1:0] p_in,
   output logic [WIDTH-1:0] g_out,
   output logic [WIDTH-1:0] p_out
);

   logic [LAST:FIRST-1][WIDTH-1:0] g_l;
   logic [LAST:FIRST-1][WIDTH-1:0] p_l;

   assign g_l[FIRST-1] = g_in;
   assign p_l[FIRST-1] = p_in;

   for (genvar k = FIRST; k <= LAST; k++) begin : g_lvl
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (((i >> (k - 1)) & 1) == 1) begin : g_op
            localparam int J = lf_partner(i, k);
            assign {g_l[k][i], p_l[k][i]} = carry_op(
               g_l[k-1][i], p_l[k-1][i],
               g_l[k-1][J], p_l[k-1][J]);
         end else begin : g_pass
            assign g_l[k][i] = g_l[k-1][i];
            assign p_l[k][i] = p_l[k-1][i];
         end
      end
   end

   assign g_out = g_l[LAST];
   assign p_out = p_l[LAST];

endmodule

// File: rtl/ublf_sub_pipe.sv
// Two-stage pipelined subtractor x - y - bin with borrow-out and flags.
// Prefix network is split around the stage-1 register at level SPLIT.
module ublf_sub_pipe
   import ublf_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SPLIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             zero,
   output logic             ovf
);

   localparam int LV = levels(WIDTH);

   if (!is_pow2(WIDTH) || WIDTH < 4) begin : g_bad_width
      $error("WIDTH must be a power of two and at least 4");
   end
   if (SPLIT < 1 || SPLIT > LV - 1) begin : g_bad_split
      $error("SPLIT must lie in 1 .. log2(WIDTH)-1");
   end

   logic [WIDTH-1:0] g0, p0, g_a, p_a, g_b, p_b;
   logic [WIDTH-1:0] s1_g, s1_p, s1_p0;
   logic             s1_valid, s1_cin, s1_xm, s1_ym;
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] d_n;
   flags_t           fl_n, fl;
   logic             adv1, adv2;

   // Subtraction as x + ~y + ~bin
   assign g0 = x & ~y;
   assign p0 = x ^ ~y;

   ublf_prefix_levels #(.WIDTH(WIDTH), .FIRST(1), .LAST(SPLIT)) u_pre (
      .g_in (g0),
      .p_in (p0),
      .g_out(g_a),
      .p_out(p_a)
   );

   assign adv2     = !out_valid || out_ready;
   assign adv1     = !s1_valid || adv2;
   assign in_ready = adv1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_g     <= '0;
         s1_p     <= '0;
         s1_p0    <= '0;
         s1_cin   <= 1'b0;
         s1_xm    <= 1'b0;
         s1_ym    <= 1'b0;
      end else if (adv1) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_g   <= g_a;
            s1_p   <= p_a;
            s1_p0  <= p0;
            s1_cin <= ~bin;
            s1_xm  <= x[WIDTH-1];
            s1_ym  <= y[WIDTH-1];
         end
      end
   end

   ublf_prefix_levels #(.WIDTH(WIDTH), .FIRST(SPLIT + 1), .LAST(LV)) u_post (
      .g_in (s1_g),
      .p_in (s1_p),
      .g_out(g_b),
      .p_out(p_b)
   );

   assign c         = {g_b | (p_b & {WIDTH{s1_cin}}), s1_cin};
   assign d_n       = s1_p0 ^ c[WIDTH-1:0];
   assign fl_n.bout = ~c[WIDTH];
   assign fl_n.zero = ~|d_n;
   assign fl_n.ovf  = (s1_xm != s1_ym) && (d_n[WIDTH-1] != s1_xm);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         d         <= '0;
         fl        <= '0;
      end else if (adv2) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            d  <= d_n;
            fl <= fl_n;
         end
      end
   end

   assign bout = fl.bout;
   assign zero = fl.zero;
   assign ovf  = fl.ovf;

endmodule

// File: doc/ublf_sub_pipe.md
Name: ublf_sub_pipe

Overview:
- Pipelined two-operand unsigned subtractor with borrow-in and borrow-out.
- It is the inverse-direction companion to the team's Ladner-Fischer adders.
- Computes D = X - Y - Bin as X + ~Y + ~Bin through a Ladner-Fischer prefix carry network, split across two register stages.
- Uses valid/ready handshakes on both sides. It sits in datapaths that need a registered, back-pressurable difference plus compare flags.

Parameters:
- WIDTH, 16, operand width. Must be a power of two and at least 4; otherwise elaboration fails.
- SPLIT, 2, number of prefix levels computed before the stage-1 register. Legal range 1 to log2(WIDTH)-1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operands valid
- in_ready  out  1  block accepts operands this cycle
- x  in  WIDTH  minuend
- y  in  WIDTH  subtrahend
- bin  in  1  borrow-in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- d  out  WIDTH  difference, modulo 2^WIDTH
- bout  out  1  borrow-out; 1 when x < y + bin (unsigned)
- zero  out  1  d == 0
- ovf  out  1  signed overflow: x[W-1] != y[W-1] and d[W-1] != x[W-1]

Behaviour:
- Reset is asynchronous active-low. While rst_n=0: both stage valids = 0, out_valid = 0, d = 0, bout = 0, zero = 0, ovf = 0.
- in_ready is combinational from the stage valids and out_ready, and is permitted to be 1 during reset.
- Reset mid-operation discards all in-flight data; nothing is replayed.
- Stage 0 (combinational, on input):
  - yi = ~y, cin = ~bin.
  - G0[i] = x[i] & yi[i], P0[i] = x[i] ^ yi[i].
  - Prefix levels 1..SPLIT use the Ladner-Fischer pattern: at level k, bit i with bit k-1 of i set combines with the group ending at bit ((i >> (k-1)) << (k-1)) - 1.
- Stage 1 register: captures G_SPLIT, P_SPLIT, P0, cin, x[W-1], y[W-1], and s1_valid.
- Stage 1 to 2 (combinational): remaining prefix levels SPLIT+1..log2(WIDTH).
  - c[i+1] = G[i] | (P[i] & cin).
  - d[0] = P0[0] ^ cin; d[i] = P0[i] ^ c[i].
  - bout = ~c[WIDTH].
  - zero and ovf are derived from d.
- Stage 2 register: d, bout, zero, ovf, out_valid.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - Stage 2 advances when !out_valid || out_ready.
  - Stage 1 advances when !s1_valid || stage-2 advance.
  - in_ready = stage-1 advance.
- Latency and throughput: exactly 2 cycles from input transfer to out_valid with no backpressure; throughput is 1 per cycle.
- Backpressure and ordering:
  - With out_ready=0, at most 2 results are held and in_ready drops after the pipe fills.
  - Order is preserved.
  - Held outputs are stable while out_valid && !out_ready.
- Bubbles: data registers load only on their stage's advance with the upstream valid set. Valid registers load on every advance, so bubbles propagate as valid=0 while the data registers keep old values.
- Simultaneous events: out_ready rising in the same cycle as in_valid with a full pipe permits a same-cycle input transfer (in_ready=1). No combinational path from in_valid to out_valid.
- Wrap-around: x=0, y=0, bin=1 gives d = all-ones, bout=1.

Decomposition:
- Package ublf_pkg:
  - function carry_op(gi1, pi1, gi2, pi2) returning {g, p}
  - localparam function levels(WIDTH) = log2
  - function lf_partner(i, k) giving the combine-source index
- One sub-module, ublf_prefix_levels (purely combinational):
  - parameters WIDTH, FIRST, LAST; ports g_in, p_in, g_out, p_out.
  - Instantiated twice: levels 1..SPLIT before the stage-1 register, SPLIT+1..log2(WIDTH) after it.

Test Plan:
- Reset then single transfer x=0x1234, y=0x0234, bin=0, out_ready=1 -> two cycles later out_valid=1, d=0x1000, bout=0, zero=0, ovf=0; one cycle later out_valid=0.
- x=0x0000, y=0x0000, bin=1 -> d=0xFFFF, bout=1, zero=0. Then x=0x8000, y=0x0001, bin=0 -> d=0x7FFF, bout=0, ovf=1. Then x=0x00FF, y=0x00FF, bin=0 -> d=0, zero=1.
- Back-to-back stream of 8 random pairs with out_ready=1 -> 8 consecutive out_valid cycles, results in order, each matching the golden model (x-y-bin) mod 2^16.
- out_ready=0 while issuing 3 inputs -> first two accepted; in_ready=0 on the third until out_ready=1; outputs held stable; all 3 emerge in order with none lost or duplicated.
- Assert rst_n=0 asynchronously mid-stream with 2 results in flight -> out_valid and all outputs clear immediately without a clock edge; after release no stale result appears.
- Exhaustive 8-bit sweep with WIDTH=8, SPLIT=1 and SPLIT=2, all x, y, bin -> d and bout match the reference for all 131072 cases.
